// File: rtl/key_debounce_repeat.sv
// rtl/key_debounce_repeat.sv - four-key debouncer with per-key press/release pulses,
// auto-repeat FSMs and left/right conflict suppression on the game action outputs.
module key_debounce_repeat #(
  parameter int unsigned DEBOUNCE_CYC = 20000,
  parameter int unsigned REPEAT_DELAY = 150000,
  parameter int unsigned REPEAT_RATE  = 30000,
  parameter logic [3:0]  REPEAT_MASK  = 4'b1110
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] key_raw,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] key_evt
);

  localparam logic [24:0] DEB_LAST = 25'(DEBOUNCE_CYC - 1);
  localparam logic [24:0] DLY_LAST = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0] RATE_LAST = 25'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_e;

  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  level_q, level_d;
  logic [3:0]  press_q, press_d;
  logic [3:0]  rel_q, rel_d;
  logic [3:0]  evt_q, evt_d;
  logic [3:0]  rep_evt;
  logic [24:0] deb_cnt_q [4];
  logic [24:0] deb_cnt_d [4];
  logic [24:0] rep_cnt_q [4];
  logic [24:0] rep_cnt_d [4];
  rep_state_e  state_q [4];
  rep_state_e  state_d [4];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      evt_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= '0;
        rep_cnt_q[i] <= '0;
        state_q[i]   <= ST_IDLE;
      end
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      evt_q   <= evt_d;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  // The counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i] = ~level_q[i];
          press_d[i] = sync2_q[i];
          rel_d[i]   = ~sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 25'd1;
        end
      end
    end
  end

  always_comb begin
    rep_evt = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i]   = state_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          rep_cnt_d[i] = '0;
          if (press_q[i] && REPEAT_MASK[i]) state_d[i] = ST_DELAY;
        end
        ST_DELAY, ST_REPEAT: begin
          if (!level_q[i]) begin
            state_d[i]   = ST_IDLE;
            rep_cnt_d[i] = '0;
          end else if (rep_cnt_q[i] == ((state_q[i] == ST_DELAY) ? DLY_LAST : RATE_LAST)) begin
            rep_evt[i]   = 1'b1;
            rep_cnt_d[i] = '0;
            state_d[i]   = ST_REPEAT;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + 25'd1;
          end
        end
        default: begin
          state_d[i]   = ST_IDLE;
          rep_cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Left and right held together cancel each other; their FSMs keep their schedule.
  always_comb begin
    evt_d = press_q | rep_evt;
    if (level_q[1] && level_q[2]) evt_d[2:1] = 2'b00;
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign key_evt     = evt_q;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// tb/tb_key_debounce_repeat.sv - randomized bench for key_debounce_repeat against a
// window/timestamp reference model, plus scenario pulse-count checks.
module tb_key_debounce_repeat;

  localparam int DEB = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam logic [3:0] MASK = 4'b1110;
  localparam int N = 2600;

  logic       CLK;
  logic       RST_N;
  logic [3:0] key_raw;
  logic [3:0] key_level, key_press, key_release, key_evt;

  key_debounce_repeat #(
    .DEBOUNCE_CYC(DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR),
    .REPEAT_MASK(MASK)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .key_raw(key_raw),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_evt(key_evt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [3:0] raw_a [N];
  logic       rst_a [N];
  logic [3:0] m_lvl [N];
  logic [3:0] m_press [N];
  logic [3:0] d_lvl [N];
  logic [3:0] d_press [N];
  logic [3:0] d_rel [N];
  logic [3:0] d_evt [N];
  int n;
  int cur_t;
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, cur_t, got, exp);
    end
  endtask

  task automatic seg(input logic [3:0] v, input logic r, input int len);
    for (int i = 0; i < len; i++) begin
      raw_a[n] = v;
      rst_a[n] = r;
      n++;
    end
  endtask

  // Value of the second synchronizer flop seen by edge t.
  function automatic logic [3:0] sync_at(input int t);
    if (t < 2) return 4'b0;
    if (rst_a[t-1] || rst_a[t-2]) return 4'b0;
    return raw_a[t-2];
  endfunction

  function automatic int count_bit(input int a, input int b, input int k, input int sel);
    int c;
    c = 0;
    for (int t = a; t <= b; t++) begin
      if (sel == 0 && d_press[t][k]) c++;
      if (sel == 1 && d_rel[t][k]) c++;
      if (sel == 2 && d_evt[t][k]) c++;
    end
    return c;
  endfunction

  int s1, sb, s3, s0, sc, sr;
  int plast [4];
  int lastlow [4];
  int rem [4];
  logic [3:0] cur;
  logic [3:0] prev, lv, pv, rv, ev, rep, sv;
  logic flip;
  int c;

  initial begin
    n = 0;
    n_checks = 0;
    n_errors = 0;
    seg(4'b0000, 1'b1, 3);
    seg(4'b0000, 1'b0, 2);
    s1 = n; seg(4'b0010, 1'b0, 8); seg(4'b0000, 1'b0, 12);
    sb = n; seg(4'b0001, 1'b0, 1); seg(4'b0000, 1'b0, 1); seg(4'b0001, 1'b0, 1);
    seg(4'b0000, 1'b0, 13);
    s3 = n; seg(4'b1000, 1'b0, 30); seg(4'b0000, 1'b0, 12);
    s0 = n; seg(4'b0001, 1'b0, 40); seg(4'b0000, 1'b0, 10);
    sc = n; seg(4'b0110, 1'b0, 25); seg(4'b0010, 1'b0, 20); seg(4'b0000, 1'b0, 12);
    sr = n; seg(4'b1000, 1'b0, 20); seg(4'b1000, 1'b1, 1); seg(4'b1000, 1'b0, 15);
    seg(4'b0000, 1'b0, 10);
    cur = 4'b0;
    for (int k = 0; k < 4; k++) rem[k] = 0;
    while (n < N) begin
      for (int k = 0; k < 4; k++) begin
        if (rem[k] == 0) begin
          cur[k] = ~cur[k];
          rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                : int'($urandom_range(5, 45));
        end
        rem[k]--;
      end
      seg(cur, ($urandom_range(0, 299) == 0), 1);
    end

    for (int k = 0; k < 4; k++) begin
      plast[k] = -1000;
      lastlow[k] = -1;
    end

    for (int t = 0; t < N; t++) begin
      key_raw = raw_a[t];
      RST_N = ~rst_a[t];
      @(posedge CLK);
      #1;
      cur_t = t;
      d_lvl[t] = key_level;
      d_press[t] = key_press;
      d_rel[t] = key_release;
      d_evt[t] = key_evt;

      prev = (t > 0) ? m_lvl[t-1] : 4'b0;
      lv = 4'b0; pv = 4'b0; rv = 4'b0; ev = 4'b0; rep = 4'b0;
      if (!rst_a[t]) begin
        // Level flips once DEB consecutive un-reset edges all saw the opposite value.
        for (int k = 0; k < 4; k++) begin
          flip = 1'b1;
          for (int j = 0; j < DEB; j++) begin
            if (t - j < 0 || rst_a[t-j]) flip = 1'b0;
            else begin
              sv = sync_at(t - j);
              if (sv[k] == prev[k]) flip = 1'b0;
            end
          end
          lv[k] = flip ? ~prev[k] : prev[k];
        end
        pv = lv & ~prev;
        rv = ~lv & prev;
        for (int k = 0; k < 4; k++) begin
          if (MASK[k] && plast[k] >= 0 && lastlow[k] < plast[k] &&
              t >= plast[k] + 1 + RD && ((t - plast[k] - 1 - RD) % RR) == 0)
            rep[k] = 1'b1;
        end
        ev = ((t > 0) ? m_press[t-1] : 4'b0) | rep;
        if (prev[1] && prev[2]) ev[2:1] = 2'b00;
      end
      m_lvl[t] = lv;
      m_press[t] = pv;
      for (int k = 0; k < 4; k++) begin
        if (pv[k]) plast[k] = t;
        if (!lv[k]) lastlow[k] = t;
      end

      check("key_level", int'(key_level), int'(lv));
      check("key_press", int'(key_press), int'(pv));
      check("key_release", int'(key_release), int'(rv));
      check("key_evt", int'(key_evt), int'(ev));
    end

    cur_t = -1;
    check("clean_lvl_before", int'(d_lvl[s1+4][1]), 0);
    check("clean_lvl_at", int'(d_lvl[s1+5][1]), 1);
    check("clean_press_at", int'(d_press[s1+5][1]), 1);
    check("clean_evt_at", int'(d_evt[s1+6][1]), 1);
    check("clean_evt_after", int'(d_evt[s1+7][1]), 0);
    c = 0;
    for (int t = sb; t <= sb + 16; t++)
      if ((d_lvl[t] | d_press[t] | d_rel[t] | d_evt[t]) != 4'b0) c++;
    check("bounce_quiet", c, 0);
    check("repeat3_evts", count_bit(s3, s3 + 41, 3, 2), 8);
    check("repeat3_press", count_bit(s3, s3 + 41, 3, 0), 1);
    check("repeat3_rel", count_bit(s3, s3 + 41, 3, 1), 1);
    check("rotate_once", count_bit(s0, s0 + 49, 0, 2), 1);
    check("conflict_press", int'(d_press[sc+5]), 6);
    check("conflict_lvl", int'(d_lvl[sc+5]), 6);
    check("conflict_quiet", count_bit(sc, sc + 30, 1, 2) + count_bit(sc, sc + 30, 2, 2), 0);
    check("conflict_resume", count_bit(sc + 31, sc + 56, 1, 2), 7);
    check("reset_pre_repeat", int'(d_evt[sr+19][3]), 1);
    check("reset_outputs", int'({d_lvl[sr+20], d_press[sr+20], d_rel[sr+20], d_evt[sr+20]}), 0);
    check("reset_no_early", count_bit(sr + 21, sr + 25, 3, 0), 0);
    check("reset_repress", int'(d_press[sr+26][3]), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/key_debounce_repeat.md
KEY_DEBOUNCE_REPEAT -- requirements
Module: key_debounce_repeat

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 20000, consecutive stable cycles required to accept a level change (range 2..2^25-1).
REQ-002 Parameter REPEAT_DELAY, default 150000, cycles from accepted press to first auto-repeat event (range 2..2^25-1).
REQ-003 Parameter REPEAT_RATE, default 30000, cycles between subsequent auto-repeat events (range 2..2^25-1).
REQ-004 Parameter REPEAT_MASK, default 4'b1110, per-key auto-repeat enable; bit0 rotate, bit1 left, bit2 right, bit3 down.
REQ-005 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-006 RST_N  input  1  reset, synchronous, active-low.
REQ-007 key_raw  input  4  raw active-high buttons {down, right, left, change}, asynchronous to CLK, may bounce.
REQ-008 key_level  output  4  debounced button level.
REQ-009 key_press  output  4  one-cycle pulse on each accepted 0->1 transition of key_level.
REQ-010 key_release  output  4  one-cycle pulse on each accepted 1->0 transition of key_level.
REQ-011 key_evt  output  4  one-cycle game action pulse: press or auto-repeat, after conflict filtering; drives the game's change/left/right/down inputs.

Function
REQ-012 Each key_raw bit SHALL pass through a 2-flop synchronizer; all further logic uses only the second flop (sync).
REQ-013 Per key, a 25-bit debounce counter SHALL increment each cycle sync != key_level and clear to 0 in any cycle sync == key_level.
REQ-014 When the counter equals DEBOUNCE_CYC-1 and sync != key_level, key_level SHALL toggle at that edge and the counter SHALL clear.
REQ-015 Latency: raw high first sampled at edge k and held -> key_level and key_press high after edge k+1+DEBOUNCE_CYC; same for release and key_release.
REQ-016 A raw pulse or glitch stable for fewer than DEBOUNCE_CYC synchronized cycles SHALL produce no change on any output.
REQ-017 key_press, key_release SHALL be registered and asserted in exactly the cycle in which key_level first shows the new value.
REQ-018 Per key, a repeat FSM SHALL have states IDLE, DELAY, REPEAT, with a 25-bit repeat counter.
REQ-019 IDLE -> DELAY on key_press when that key's REPEAT_MASK bit is 1; counter cleared.
REQ-020 In DELAY, the counter increments; when it reaches REPEAT_DELAY-1, a repeat event is raised, the counter clears, and the FSM moves to REPEAT.
REQ-021 In REPEAT, the counter increments; each time it reaches REPEAT_RATE-1, a repeat event is raised and the counter clears.
REQ-022 DELAY or REPEAT -> IDLE in the cycle key_level goes 0, counter cleared, and no repeat event in that cycle.
REQ-023 Keys with REPEAT_MASK bit 0 SHALL stay in IDLE; they produce exactly one key_evt per press.
REQ-024 Unfiltered event = key_press OR repeat event; key_evt SHALL be registered, one cycle later than key_press.
REQ-025 Conflict: while key_level[1] and key_level[2] are both 1, key_evt[1] and key_evt[2] SHALL be 0; both FSMs keep counting, and events resume when one is released.
REQ-026 Keys are independent; simultaneous presses on different keys SHALL each yield their own pulses in the same cycle (subject to REQ-025).
REQ-027 key_press and key_release SHALL never both be 1 for the same key in one cycle; no output pulse exceeds one cycle.

Reset
REQ-028 While RST_N=0 at a clock edge: synchronizers, key_level, key_press, key_release, key_evt = 0; all counters = 0; all FSMs = IDLE.
REQ-029 Reset asserted mid-debounce or mid-repeat SHALL abort it; outputs are 0 after that edge, and no pulse is emitted on reset exit.
REQ-030 A key held through reset release SHALL be treated as a new press: key_press occurs DEBOUNCE_CYC+1 cycles after the first edge with RST_N=1.

Verification (bench parameters DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-031 Clean press: key_raw[1] 0->1 sampled at edge 0 and held 8 cycles -> key_level[1] and key_press[1] high after edge 5; key_evt[1] high after edge 6, single cycle.
REQ-032 Bounce: key_raw[0] toggles 1,0,1,0 on successive edges, then stays 0 -> all outputs remain 0.
REQ-033 Auto-repeat: key_raw[3] held 30 cycles -> key_evt[3] at press+1, then first repeat 10 cycles after press, then every 3 cycles; stops on release with a single key_release[3] pulse.
REQ-034 No repeat on rotate: key_raw[0] held 40 cycles -> exactly one key_evt[0].
REQ-035 Left+right conflict: both held together -> key_level=4'b0110, key_press=4'b0110 pulse, key_evt[2:1]=0 throughout; release right -> left repeat events resume on its existing schedule.
REQ-036 Reset mid-repeat: RST_N=0 for one edge while in REPEAT -> all outputs 0; key still held -> new key_press 5 cycles after RST_N returns to 1.
